// File: rtl/gray_switch_conditioner.sv
// gray_switch_conditioner
//
// Purpose: conditions the raw board switches that carry a Gray code word
// before they reach the Gray decoder. The switches are synchronized to clk,
// debounced, and presented as a stable Gray word. Each accepted word raises
// a one-cycle strobe. A word that differs from the previous output in other
// than exactly one bit is flagged as an illegal Gray step.
//
// Parameters:
//   WIDTH           - width of the switch and Gray buses
//   DEBOUNCE_CYCLES - consecutive clocks a new value must hold before it is
//                     accepted (>= 1)
//   CNT_W           - debounce counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   sw_in           in   raw switch levels, asynchronous to clk, may bounce
//   gray_out        out  debounced Gray word (drives the decoder gray_in)
//   gray_valid      out  one-cycle pulse in the cycle gray_out takes a new value
//   gray_step_err   out  one-cycle pulse with gray_valid when the accepted word
//                        differs from the previous gray_out in 0 or >=2 bits
//   gray_err_sticky out  latched copy of any gray_step_err, cleared by rst only

module gray_switch_conditioner #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] gray_out,
   output logic             gray_valid,
   output logic             gray_step_err,
   output logic             gray_err_sticky
);

   // Terminal count of the debounce window: the commit happens on the edge
   // where the counter already holds this value and the input is unchanged.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] WORD_ONE = WIDTH'(1);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] w_cand_next;
   logic [WIDTH-1:0] r_gray;
   logic [WIDTH-1:0] w_gray_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_valid;
   logic             w_valid_next;
   logic             r_step_err;
   logic             w_step_err_next;
   logic             r_sticky;

   logic [WIDTH-1:0] w_diff;
   logic             w_single_bit;

   // A legal Gray step flips exactly one bit: the difference is non-zero and
   // clearing its lowest set bit leaves nothing behind.
   assign w_diff       = r_cand ^ r_gray;
   assign w_single_bit = (w_diff != '0) && ((w_diff & (w_diff - WORD_ONE)) == '0);

   // Two-flop synchronizer; nothing downstream looks at r_sync1 or sw_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sw_in;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce FSM: next state and next register values.
   always_comb begin
      w_state_next    = r_state;
      w_cand_next     = r_cand;
      w_cnt_next      = r_cnt;
      w_gray_next     = r_gray;
      w_valid_next    = 1'b0;
      w_step_err_next = 1'b0;

      case (r_state)
         ST_STABLE: begin
            if (r_sync2 != r_gray) begin
               w_cand_next  = r_sync2;
               w_cnt_next   = '0;
               w_state_next = ST_SETTLING;
            end
         end

         ST_SETTLING: begin
            if (r_sync2 != r_cand) begin
               // Input moved again: restart the full window on the new value.
               w_cand_next = r_sync2;
               w_cnt_next  = '0;
            end else if (r_sync2 == r_gray) begin
               // Bounced back to the committed word; nothing to accept.
               w_state_next = ST_STABLE;
            end else if (r_cnt == CNT_LAST) begin
               w_gray_next     = r_cand;
               w_valid_next    = 1'b1;
               w_step_err_next = ~w_single_bit;
               w_state_next    = ST_STABLE;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end

         default: begin
            w_state_next = ST_STABLE;
         end
      endcase
   end

   // Debounce FSM: state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_STABLE;
         r_cand     <= '0;
         r_cnt      <= '0;
         r_gray     <= '0;
         r_valid    <= 1'b0;
         r_step_err <= 1'b0;
         r_sticky   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cand     <= w_cand_next;
         r_cnt      <= w_cnt_next;
         r_gray     <= w_gray_next;
         r_valid    <= w_valid_next;
         r_step_err <= w_step_err_next;
         // Uses the next-cycle error so the sticky flag rises with the pulse.
         r_sticky   <= r_sticky | w_step_err_next;
      end
   end

   assign gray_out        = r_gray;
   assign gray_valid      = r_valid;
   assign gray_step_err   = r_step_err;
   assign gray_err_sticky = r_sticky;

endmodule

// File: tb/tb_gray_switch_conditioner.sv
// Self-checking bench for gray_switch_conditioner with DEBOUNCE_CYCLES=4.
// The reference model works on run lengths: the FSM sees the switches two
// edges late, and a word is accepted on the edge that completes a run of
// DEBOUNCE_CYCLES+1 identical observed samples differing from the output.

module tb_gray_switch_conditioner;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] sw_in;
   logic [W-1:0] gray_out;
   logic         gray_valid;
   logic         gray_step_err;
   logic         gray_err_sticky;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   gray_switch_conditioner #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sw_in          (sw_in),
      .gray_out       (gray_out),
      .gray_valid     (gray_valid),
      .gray_step_err  (gray_step_err),
      .gray_err_sticky(gray_err_sticky)
   );

   // ---------------- reference model ----------------
   logic [W-1:0] m_d1, m_d2;      // two-edge delay of the sampled switches
   logic [W-1:0] m_hist[$];       // last D+1 values seen by the debouncer
   logic [W-1:0] m_out;
   logic         m_valid, m_err, m_sticky;

   task automatic model_reset();
      m_d1 = '0;
      m_d2 = '0;
      m_hist.delete();
      m_out    = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_sticky = 1'b0;
   endtask

   task automatic model_edge(input logic [W-1:0] sampled);
      logic [W-1:0] seen;
      bit           steady;
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = sampled;
      m_hist.push_back(seen);
      if (m_hist.size() > D + 1) void'(m_hist.pop_front());
      m_valid = 1'b0;
      m_err   = 1'b0;
      steady  = (m_hist.size() == D + 1);
      foreach (m_hist[i]) if (m_hist[i] != seen) steady = 1'b0;
      if (steady && seen != m_out) begin
         m_err    = ($countones(seen ^ m_out) != 1);
         m_valid  = 1'b1;
         m_out    = seen;
         m_sticky = m_sticky | m_err;
      end
   endtask

   // Drive one switch value, let one rising edge pass, advance the model,
   // and leave time 1 unit after the edge for sampling.
   task automatic step(input logic [W-1:0] sw);
      sw_in = sw;
      @(posedge clk);
      model_edge(sw);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst   = 1'b1;
      sw_in = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== 7'b0)
         $display("FAIL reset_outputs: got %b required 0000000",
                  {gray_out, gray_valid, gray_step_err, gray_err_sticky});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         step('0);
         n_checks++;
         if (gray_valid !== 1'b0 || gray_out !== 4'b0000)
            $display("FAIL reset_idle cycle %0d: got out=%b valid=%b required out=0000 valid=0",
                     i, gray_out, gray_valid);
         else n_pass++;
      end
      $display("test_reset: done");
   endtask

   task automatic test_clean_step();
      for (int i = 0; i < 8; i++) begin
         step(4'b0001);
         if (i == 5) begin
            n_checks++;
            if (gray_out !== 4'b0000 || gray_valid !== 1'b0)
               $display("FAIL clean_k5: got out=%b valid=%b required out=0000 valid=0",
                        gray_out, gray_valid);
            else n_pass++;
         end
         if (i == 6) begin
            n_checks++;
            if (gray_out !== 4'b0001 || gray_valid !== 1'b1 || gray_step_err !== 1'b0)
               $display("FAIL clean_k6: got out=%b valid=%b err=%b required out=0001 valid=1 err=0",
                        gray_out, gray_valid, gray_step_err);
            else n_pass++;
         end
         n_checks++;
         if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== {m_out, m_valid, m_err, m_sticky})
            $display("FAIL clean_model cycle %0d: got out=%b v=%b e=%b s=%b required out=%b v=%b e=%b s=%b",
                     i, gray_out, gray_valid, gray_step_err, gray_err_sticky, m_out, m_valid, m_err, m_sticky);
         else n_pass++;
      end
      $display("test_clean_step: gray_out=%b", gray_out);
   endtask

   task automatic test_bounce();
      logic [W-1:0] v;
      for (int i = 0; i < 20; i++) begin
         v = (i < 10 && ((i / 2) % 2 == 1)) ? 4'b0001 : 4'b0011;
         step(v);
         if (i < 14) begin
            n_checks++;
            if (gray_valid !== 1'b0 || gray_out !== 4'b0001)
               $display("FAIL bounce_hold cycle %0d: got out=%b valid=%b required out=0001 valid=0",
                        i, gray_out, gray_valid);
            else n_pass++;
         end
         if (i == 14) begin
            n_checks++;
            if (gray_out !== 4'b0011 || gray_valid !== 1'b1 || gray_step_err !== 1'b0)
               $display("FAIL bounce_commit: got out=%b valid=%b err=%b required out=0011 valid=1 err=0",
                        gray_out, gray_valid, gray_step_err);
            else n_pass++;
         end
         n_checks++;
         if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== {m_out, m_valid, m_err, m_sticky})
            $display("FAIL bounce_model cycle %0d: got out=%b v=%b e=%b s=%b required out=%b v=%b e=%b s=%b",
                     i, gray_out, gray_valid, gray_step_err, gray_err_sticky, m_out, m_valid, m_err, m_sticky);
         else n_pass++;
      end
      $display("test_bounce: gray_out=%b", gray_out);
   endtask

   task automatic test_illegal_step();
      for (int i = 0; i < 8; i++) begin
         step(4'b0110);
         if (i == 6) begin
            n_checks++;
            if (gray_out !== 4'b0110 || gray_valid !== 1'b1 || gray_step_err !== 1'b1 || gray_err_sticky !== 1'b1)
               $display("FAIL illegal_commit: got out=%b v=%b e=%b s=%b required out=0110 v=1 e=1 s=1",
                        gray_out, gray_valid, gray_step_err, gray_err_sticky);
            else n_pass++;
         end
         n_checks++;
         if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== {m_out, m_valid, m_err, m_sticky})
            $display("FAIL illegal_model cycle %0d: got out=%b v=%b e=%b s=%b required out=%b v=%b e=%b s=%b",
                     i, gray_out, gray_valid, gray_step_err, gray_err_sticky, m_out, m_valid, m_err, m_sticky);
         else n_pass++;
      end
      for (int i = 0; i < 8; i++) begin
         step(4'b0111);
         n_checks++;
         if (gray_err_sticky !== 1'b1)
            $display("FAIL sticky_hold cycle %0d: got %b required 1", i, gray_err_sticky);
         else n_pass++;
         if (i == 6) begin
            n_checks++;
            if (gray_out !== 4'b0111 || gray_valid !== 1'b1 || gray_step_err !== 1'b0)
               $display("FAIL legal_after_illegal: got out=%b v=%b e=%b required out=0111 v=1 e=0",
                        gray_out, gray_valid, gray_step_err);
            else n_pass++;
         end
      end
      $display("test_illegal_step: gray_out=%b sticky=%b", gray_out, gray_err_sticky);
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 13; i++) begin
         step((i < 3) ? 4'b0101 : 4'b0111);
         n_checks++;
         if (gray_out !== 4'b0111 || gray_valid !== 1'b0)
            $display("FAIL glitch cycle %0d: got out=%b valid=%b required out=0111 valid=0",
                     i, gray_out, gray_valid);
         else n_pass++;
      end
      $display("test_glitch: gray_out=%b", gray_out);
   endtask

   task automatic test_reset_mid_settling();
      for (int i = 0; i < 3; i++) step(4'b1111);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== 7'b0)
         $display("FAIL midreset_immediate: got %b required 0000000",
                  {gray_out, gray_valid, gray_step_err, gray_err_sticky});
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (gray_out !== 4'b0000 || gray_err_sticky !== 1'b0)
         $display("FAIL midreset_held: got out=%b sticky=%b required out=0000 sticky=0",
                  gray_out, gray_err_sticky);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         step(4'b1111);
         if (i == 5) begin
            n_checks++;
            if (gray_out !== 4'b0000 || gray_valid !== 1'b0)
               $display("FAIL midreset_k5: got out=%b valid=%b required out=0000 valid=0",
                        gray_out, gray_valid);
            else n_pass++;
         end
         if (i == 6) begin
            n_checks++;
            if (gray_out !== 4'b1111 || gray_valid !== 1'b1 || gray_step_err !== 1'b1 || gray_err_sticky !== 1'b1)
               $display("FAIL midreset_commit: got out=%b v=%b e=%b s=%b required out=1111 v=1 e=1 s=1",
                        gray_out, gray_valid, gray_step_err, gray_err_sticky);
            else n_pass++;
         end
         n_checks++;
         if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== {m_out, m_valid, m_err, m_sticky})
            $display("FAIL midreset_model cycle %0d: got out=%b v=%b e=%b s=%b required out=%b v=%b e=%b s=%b",
                     i, gray_out, gray_valid, gray_step_err, gray_err_sticky, m_out, m_valid, m_err, m_sticky);
         else n_pass++;
      end
      $display("test_reset_mid_settling: gray_out=%b", gray_out);
   endtask

   task automatic test_random();
      logic [W-1:0] v;
      int           len;
      int           cyc       = 0;
      int           last_pulse = -1000;
      for (int seg = 0; seg < 60; seg++) begin
         v   = W'($urandom_range(0, 15));
         len = $urandom_range(1, 9);
         for (int j = 0; j < len; j++) begin
            step(v);
            cyc++;
            n_checks++;
            if ({gray_out, gray_valid, gray_step_err, gray_err_sticky} !== {m_out, m_valid, m_err, m_sticky})
               $display("FAIL random_model cycle %0d: got out=%b v=%b e=%b s=%b required out=%b v=%b e=%b s=%b",
                        cyc, gray_out, gray_valid, gray_step_err, gray_err_sticky, m_out, m_valid, m_err, m_sticky);
            else n_pass++;
            if (gray_valid === 1'b1) begin
               n_checks++;
               if (cyc - last_pulse < D + 1)
                  $display("FAIL random_spacing cycle %0d: got gap %0d required >= %0d",
                           cyc, cyc - last_pulse, D + 1);
               else n_pass++;
               last_pulse = cyc;
               $display("random commit cycle %0d: gray_out=%b step_err=%b", cyc, gray_out, gray_step_err);
            end
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      sw_in = '0;
      model_reset();
      test_reset();
      test_clean_step();
      test_bounce();
      test_illegal_step();
      test_glitch();
      test_reset_mid_settling();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
